// File: rtl/layer_blend.sv
// Three-layer RGBA alpha compositor over a fixed backdrop colour.
// Bottom, middle and top layers blend in successive stages; syncs and bright share the 3-cycle latency.
module layer_blend #(
    parameter logic [23:0] BG_RGB    = 24'h000000,
    parameter logic        SYNC_IDLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] color_rgba_top,
    input  logic [31:0] color_rgba_mid,
    input  logic [31:0] color_rgba_bot,
    input  logic        bright_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [23:0] rgb_out,
    output logic        bright_out,
    output logic        hsync_out,
    output logic        vsync_out
);

    // Alpha 255 is promoted to 256 so full opacity reproduces fg exactly.
    function automatic logic [7:0] blend_ch(input logic [7:0] fg, input logic [7:0] bg,
                                            input logic [7:0] a);
        logic [8:0]  a9;
        logic [8:0]  inv9;
        logic [15:0] sum;
        a9   = {1'b0, a} + {8'd0, a[7]};
        inv9 = 9'd256 - a9;
        sum  = ({8'd0, fg} * {7'd0, a9}) + ({8'd0, bg} * {7'd0, inv9});
        return sum[15:8];
    endfunction

    function automatic logic [23:0] blend_px(input logic [31:0] fg_rgba, input logic [23:0] bg);
        return {blend_ch(fg_rgba[31:24], bg[23:16], fg_rgba[7:0]),
                blend_ch(fg_rgba[23:16], bg[15:8],  fg_rgba[7:0]),
                blend_ch(fg_rgba[15:8],  bg[7:0],   fg_rgba[7:0])};
    endfunction

    logic [23:0] s1_rgb_r;
    logic [23:0] s2_rgb_r;
    logic [31:0] mid_d1_r;
    logic [31:0] top_d1_r;
    logic [31:0] top_d2_r;
    logic [1:0]  bright_sr_r;
    logic [1:0]  hsync_sr_r;
    logic [1:0]  vsync_sr_r;
    logic [23:0] s3_rgb_s;

    // Stage 1: bottom layer over backdrop; hold upper layers for alignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rgb_r <= 24'h000000;
            mid_d1_r <= 32'h00000000;
            top_d1_r <= 32'h00000000;
        end else begin
            s1_rgb_r <= blend_px(color_rgba_bot, BG_RGB);
            mid_d1_r <= color_rgba_mid;
            top_d1_r <= color_rgba_top;
        end
    end

    // Stage 2: middle layer over stage-1 result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_rgb_r <= 24'h000000;
            top_d2_r <= 32'h00000000;
        end else begin
            s2_rgb_r <= blend_px(mid_d1_r, s1_rgb_r);
            top_d2_r <= top_d1_r;
        end
    end

    // Stage 3 next value: top layer over stage-2 result, blanked outside the visible area.
    always_comb begin
        s3_rgb_s = 24'h000000;
        if (bright_sr_r[1]) begin
            s3_rgb_s = blend_px(top_d2_r, s2_rgb_r);
        end else begin
            s3_rgb_s = 24'h000000;
        end
    end

    // Timing-signal delay lines; the output registers form the third stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            bright_sr_r <= 2'b00;
            hsync_sr_r  <= {2{SYNC_IDLE}};
            vsync_sr_r  <= {2{SYNC_IDLE}};
        end else begin
            bright_sr_r <= {bright_sr_r[0], bright_in};
            hsync_sr_r  <= {hsync_sr_r[0], hsync_in};
            vsync_sr_r  <= {vsync_sr_r[0], vsync_in};
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out    <= 24'h000000;
            bright_out <= 1'b0;
            hsync_out  <= SYNC_IDLE;
            vsync_out  <= SYNC_IDLE;
        end else begin
            rgb_out    <= s3_rgb_s;
            bright_out <= bright_sr_r[1];
            hsync_out  <= hsync_sr_r[1];
            vsync_out  <= vsync_sr_r[1];
        end
    end

endmodule

// File: tb/tb_layer_blend.sv
// Directed bench for layer_blend with a non-black backdrop (BG_RGB = 123456).
// Expected values are hand-computed from the blend equation.
module tb_layer_blend;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] top, mid, bot;
    logic        bright_in, hsync_in, vsync_in;
    logic [23:0] rgb_out;
    logic        bright_out, hsync_out, vsync_out;

    int n_checks = 0;
    int n_fails  = 0;

    layer_blend #(.BG_RGB(24'h123456), .SYNC_IDLE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .color_rgba_top(top), .color_rgba_mid(mid), .color_rgba_bot(bot),
        .bright_in(bright_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_out(rgb_out), .bright_out(bright_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one input cycle, then step past the rising edge.
    task automatic drive(input logic [31:0] t, input logic [31:0] m, input logic [31:0] b,
                         input logic br, input logic hs, input logic vs);
        top = t; mid = m; bot = b;
        bright_in = br; hsync_in = hs; vsync_in = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        top = 32'h0; mid = 32'h0; bot = 32'h0;
        bright_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_rgb", rgb_out, 24'h000000);
        chk("reset_bright", {23'd0, bright_out}, 24'd0);
        chk("reset_hsync", {23'd0, hsync_out}, 24'd1);
        chk("reset_vsync", {23'd0, vsync_out}, 24'd1);
        rst = 1'b0;

        // Three back-to-back pixels, one per cycle.
        drive(32'hFF0000FF, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b1);
        chk("lat_rgb_e1", rgb_out, 24'h000000);
        drive(32'h00000000, 32'h00FF00FF, 32'hABCDEF77, 1'b1, 1'b1, 1'b1);
        chk("lat_rgb_e2", rgb_out, 24'h000000);
        drive(32'hFFFFFF80, 32'h000000FF, 32'h00000000, 1'b1, 1'b1, 1'b1);
        chk("top_opaque_red", rgb_out, 24'hFF0000);
        chk("bright_on", {23'd0, bright_out}, 24'd1);
        idle();
        chk("mid_opaque_green", rgb_out, 24'h00FF00);
        idle();
        chk("top_half_white", rgb_out, 24'h808080);
        idle();
        chk("blank_after_stream", rgb_out, 24'h000000);
        chk("bright_off", {23'd0, bright_out}, 24'd0);

        // Transparent layers show the backdrop; bright_in=0 blanks it.
        drive(32'h11111100, 32'h22222200, 32'h33333300, 1'b1, 1'b1, 1'b1);
        drive(32'h11111100, 32'h22222200, 32'h33333300, 1'b0, 1'b1, 1'b1);
        drive(32'h00000000, 32'h00000000, 32'hFFFFFF80, 1'b1, 1'b1, 1'b1);
        chk("backdrop", rgb_out, 24'h123456);
        idle();
        chk("backdrop_blanked", rgb_out, 24'h000000);
        chk("backdrop_bright_off", {23'd0, bright_out}, 24'd0);
        idle();
        chk("bot_half_over_bg", rgb_out, 24'h899AAB);

        // hsync pulse at N, vsync pulse at N+1.
        idle();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("hs_n1", {23'd0, hsync_out}, 24'd1);
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("hs_n2", {23'd0, hsync_out}, 24'd1);
        idle();
        chk("hs_n3", {23'd0, hsync_out}, 24'd0);
        chk("vs_n3", {23'd0, vsync_out}, 24'd1);
        idle();
        chk("hs_n4", {23'd0, hsync_out}, 24'd1);
        chk("vs_n4", {23'd0, vsync_out}, 24'd0);
        idle();
        chk("vs_n5", {23'd0, vsync_out}, 24'd1);

        // Opaque white stream, then a one-cycle reset mid-stream.
        for (int i = 0; i < 4; i++) begin
            drive(32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("white_stream", rgb_out, 24'hFFFFFF);
        rst = 1'b1;
        drive(32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk("mid_reset_rgb", rgb_out, 24'h000000);
        chk("mid_reset_hsync", {23'd0, hsync_out}, 24'd1);
        chk("mid_reset_vsync", {23'd0, vsync_out}, 24'd1);
        drive(32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
        chk("post_reset_e1", rgb_out, 24'h000000);
        idle();
        chk("post_reset_e2", rgb_out, 24'h000000);
        chk("post_reset_hs_e2", {23'd0, hsync_out}, 24'd1);
        idle();
        chk("post_reset_first_px", rgb_out, 24'h123456);
        chk("post_reset_hs_e3", {23'd0, hsync_out}, 24'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
